// File: rtl/frame_bank_arbiter_pkg.sv
// frame_buf_pkg: shared types and helpers for the frame bank arbiter.
//   state_e          : burst scheduler FSM states (IDLE / CMD / DATA)
//   GNT_WR / GNT_RD  : grant encoding (1 = write port, 0 = read port)
//   next_free_bank   : the bank that is neither w nor r, given that the
//                      three bank indices are a permutation of {0,1,2}
package frame_buf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  localparam logic GNT_WR = 1'b1;
  localparam logic GNT_RD = 1'b0;

  function automatic logic [1:0] next_free_bank(input logic [1:0] w, input logic [1:0] r);
    return 2'd3 - w - r;
  endfunction

endpackage

// File: rtl/frame_bank_arbiter_if.sv
// frame_bank_arbiter_if: burst command bus between the arbiter and the
// DDR3 controller command port.
//   cmd_valid  : command valid (arbiter -> controller)
//   cmd_write  : 1 = write burst, 0 = read burst
//   cmd_addr   : burst start address
//   cmd_len    : burst length
//   cmd_ready  : controller accepts the command (controller -> arbiter)
//   burst_done : data phase of the accepted burst has finished
interface frame_bank_arbiter_if #(
  parameter int ADDR_W = 29
);
  logic              cmd_valid;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              cmd_ready;
  logic              burst_done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  cmd_ready, burst_done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    output cmd_ready, burst_done
  );
endinterface

// File: rtl/frame_bank_arbiter_bank_rotator.sv
// bank_rotator: triple-buffer bank bookkeeping.
// Holds W (bank being written), R (bank being displayed), L (latest
// complete frame) and l_valid. A write swap with a complete frame publishes
// W as the latest frame and moves the writer to the free bank; a read swap
// takes the latest frame if one exists. When both swaps happen together the
// read swap sees the result of the write swap.
//   clk, reset    : clock, synchronous active-high reset
//   wr_swap       : write frame event taken this cycle
//   wr_complete   : the write frame being closed is complete
//   rd_swap       : read frame event taken this cycle
//   w_q, r_q      : registered W and R
//   w_d, r_d      : W and R after this cycle's swaps
//   rd_repeat     : read swap found no new frame (reader re-shows R)
module bank_rotator
  import frame_buf_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_swap,
  input  logic       wr_complete,
  input  logic       rd_swap,
  output logic [1:0] w_q,
  output logic [1:0] r_q,
  output logic [1:0] w_d,
  output logic [1:0] r_d,
  output logic       rd_repeat
);

  logic [1:0] l_q, l_d;
  logic       lv_q, lv_d;
  logic [1:0] w_mid, l_mid;
  logic       lv_mid;

  always_comb begin
    w_mid     = w_q;
    l_mid     = l_q;
    lv_mid    = lv_q;
    if (wr_swap && wr_complete) begin
      l_mid  = w_q;
      w_mid  = next_free_bank(w_q, r_q);
      lv_mid = 1'b1;
    end

    // Read swap works on the post-write-swap view of L.
    w_d       = w_mid;
    r_d       = r_q;
    l_d       = l_mid;
    lv_d      = lv_mid;
    rd_repeat = 1'b0;
    if (rd_swap) begin
      if (lv_mid) begin
        r_d  = l_mid;
        l_d  = r_q;
        lv_d = 1'b0;
      end else begin
        rd_repeat = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_q  <= 2'd0;
      r_q  <= 2'd1;
      l_q  <= 2'd2;
      lv_q <= 1'b0;
    end else begin
      w_q  <= w_d;
      r_q  <= r_d;
      l_q  <= l_d;
      lv_q <= lv_d;
    end
  end

endmodule

// File: rtl/frame_bank_arbiter.sv
// frame_bank_arbiter: schedules DDR3 write bursts (camera side) and read
// bursts (display side) one at a time and rotates three frame banks so the
// display never reads the bank being written.
//   clk, reset       : DDR user clock, synchronous active-high reset
//   wr_frame_start   : camera vsync pulse
//   rd_frame_start   : display vsync pulse
//   wr_req / rd_req  : write FIFO has a burst / read FIFO has room for one
//   cmd_if (master)  : burst command bus to the controller
//   wr_bank, rd_bank : bank being written / displayed
//   frame_drop       : pulse, an incomplete write frame was discarded
//   frame_repeat     : pulse, reader re-shows its bank
//   busy             : scheduler not idle
module frame_bank_arbiter
  import frame_buf_pkg::*;
#(
  parameter int          ADDR_W       = 29,
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned BANK_SIZE    = 2073600,
  parameter int unsigned BURST_STRIDE = 1920,
  parameter int unsigned BURST_LEN    = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_frame_start,
  input  logic       rd_frame_start,
  input  logic       wr_req,
  input  logic       rd_req,
  frame_bank_arbiter_if.master cmd_if,
  output logic [1:0] wr_bank,
  output logic [1:0] rd_bank,
  output logic       frame_drop,
  output logic       frame_repeat,
  output logic       busy
);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] BANK_A   = ADDR_W'(BANK_SIZE);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(BURST_STRIDE);
  localparam logic [7:0]        LEN_A    = 8'(BURST_LEN);

  function automatic logic [ADDR_W-1:0] sat_step(input logic [ADDR_W-1:0] off);
    if (off >= BANK_A - STRIDE_A) return BANK_A;
    return off + STRIDE_A;
  endfunction

  function automatic logic [ADDR_W-1:0] bank_addr(input logic [1:0] bank,
                                                  input logic [ADDR_W-1:0] off);
    return BASE_A + {{(ADDR_W-2){1'b0}}, bank} * BANK_A + off;
  endfunction

  state_e            state_q, state_d;
  logic              gnt_q, gnt_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] wr_off_q, wr_off_d;
  logic [ADDR_W-1:0] rd_off_q, rd_off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [7:0]        len_q, len_d;
  logic              wr_pend_q, wr_pend_d;
  logic              rd_pend_q, rd_pend_d;
  logic              drop_q, drop_d;
  logic              rep_q, rep_d;

  logic              wr_active, rd_active;
  logic              wr_event, rd_event;
  logic              wr_swap, rd_swap, wr_complete, rd_repeat;
  logic [ADDR_W-1:0] wr_off_eff, rd_off_eff;
  logic              wr_elig, rd_elig, pick;
  logic [1:0]        w_q, r_q, w_d, r_d;

  // Frame events: a port with a burst in flight defers its own event until
  // the scheduler is back in IDLE; the other port's event is taken at once.
  always_comb begin
    wr_active   = (state_q != ST_IDLE) && (gnt_q == GNT_WR);
    rd_active   = (state_q != ST_IDLE) && (gnt_q == GNT_RD);
    wr_event    = wr_frame_start || wr_pend_q;
    rd_event    = rd_frame_start || rd_pend_q;
    wr_swap     = wr_event && !wr_active;
    rd_swap     = rd_event && !rd_active;
    wr_pend_d   = wr_event && wr_active;
    rd_pend_d   = rd_event && rd_active;
    wr_complete = (wr_off_q == BANK_A);
    wr_off_eff  = wr_swap ? '0 : wr_off_q;
    rd_off_eff  = rd_swap ? '0 : rd_off_q;
    wr_elig     = wr_req && (wr_off_eff != BANK_A);
    rd_elig     = rd_req && (rd_off_eff != BANK_A);
    drop_d      = wr_swap && !wr_complete;
    rep_d       = rd_repeat;
  end

  bank_rotator u_rot (
    .clk         (clk),
    .reset       (reset),
    .wr_swap     (wr_swap),
    .wr_complete (wr_complete),
    .rd_swap     (rd_swap),
    .w_q         (w_q),
    .r_q         (r_q),
    .w_d         (w_d),
    .r_d         (r_d),
    .rd_repeat   (rd_repeat)
  );

  // Scheduler: the grant in IDLE already sees this cycle's swaps, so a burst
  // granted alongside a frame event starts at the new bank base.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    addr_d   = addr_q;
    write_d  = write_q;
    len_d    = len_q;
    wr_off_d = wr_off_eff;
    rd_off_d = rd_off_eff;
    pick     = GNT_RD;

    if (wr_elig && rd_elig) pick = (last_q == GNT_WR) ? GNT_RD : GNT_WR;
    else if (wr_elig)       pick = GNT_WR;

    case (state_q)
      ST_IDLE: begin
        if (wr_elig || rd_elig) begin
          gnt_d   = pick;
          last_d  = pick;
          write_d = pick;
          len_d   = LEN_A;
          addr_d  = (pick == GNT_WR) ? bank_addr(w_d, wr_off_eff)
                                     : bank_addr(r_d, rd_off_eff);
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        if (cmd_if.cmd_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cmd_if.burst_done) begin
          if (gnt_q == GNT_WR) wr_off_d = sat_step(wr_off_q);
          else                 rd_off_d = sat_step(rd_off_q);
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      gnt_q     <= GNT_RD;
      last_q    <= GNT_WR;
      wr_off_q  <= '0;
      rd_off_q  <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      len_q     <= '0;
      wr_pend_q <= 1'b0;
      rd_pend_q <= 1'b0;
      drop_q    <= 1'b0;
      rep_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      wr_off_q  <= wr_off_d;
      rd_off_q  <= rd_off_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      len_q     <= len_d;
      wr_pend_q <= wr_pend_d;
      rd_pend_q <= rd_pend_d;
      drop_q    <= drop_d;
      rep_q     <= rep_d;
    end
  end

  assign cmd_if.cmd_valid = (state_q == ST_CMD);
  assign cmd_if.cmd_write = write_q;
  assign cmd_if.cmd_addr  = addr_q;
  assign cmd_if.cmd_len   = len_q;
  assign wr_bank          = w_q;
  assign rd_bank          = r_q;
  assign frame_drop       = drop_q;
  assign frame_repeat     = rep_q;
  assign busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_frame_bank_arbiter.sv
// Self-checking bench for frame_bank_arbiter: a transaction-level model of
// the triple buffer and burst scheduler is stepped once per clock and every
// output is compared to it; directed scenarios add literal expectations.
module tb_frame_bank_arbiter;

  localparam int          TB_ADDR_W = 29;
  localparam int unsigned TB_BASE   = 32'h1000;
  localparam int unsigned TB_STRIDE = 1920;
  localparam int unsigned TB_BANK   = 1920 * 8;
  localparam int unsigned TB_LEN    = 240;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b1;
  logic wr_frame_start = 1'b0, rd_frame_start = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic cmd_ready = 1'b0, burst_done = 1'b0;
  logic [1:0] wr_bank, rd_bank;
  logic frame_drop, frame_repeat, busy;

  frame_bank_arbiter_if #(.ADDR_W(TB_ADDR_W)) cif ();
  assign cif.cmd_ready  = cmd_ready;
  assign cif.burst_done = burst_done;

  frame_bank_arbiter #(
    .ADDR_W(TB_ADDR_W), .BASE_ADDR(TB_BASE), .BANK_SIZE(TB_BANK),
    .BURST_STRIDE(TB_STRIDE), .BURST_LEN(TB_LEN)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_frame_start(wr_frame_start), .rd_frame_start(rd_frame_start),
    .wr_req(wr_req), .rd_req(rd_req),
    .cmd_if(cif),
    .wr_bank(wr_bank), .rd_bank(rd_bank),
    .frame_drop(frame_drop), .frame_repeat(frame_repeat), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic void chk(string nm, longint act, longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  int  m_w, m_r, m_l;        // bank indices
  bit  m_lv;                 // latest frame available
  longint m_woff, m_roff;    // per-port frame offsets
  bit  m_wpend, m_rpend;     // deferred frame events
  bit  m_bact;               // a burst is outstanding
  bit  m_bwrite;             // outstanding burst direction
  bit  m_acc;                // outstanding burst command accepted
  bit  m_lastw;              // last grant was the write port
  longint m_addr;            // last issued command
  bit  m_write;
  int  m_len;
  bit  m_drop, m_rep;

  function automatic void model_reset();
    m_w = 0; m_r = 1; m_l = 2; m_lv = 0;
    m_woff = 0; m_roff = 0; m_wpend = 0; m_rpend = 0;
    m_bact = 0; m_bwrite = 0; m_acc = 0; m_lastw = 1;
    m_addr = 0; m_write = 0; m_len = 0; m_drop = 0; m_rep = 0;
  endfunction

  function automatic void model_step();
    bit wev, rev, wsw, rsw, we, re;
    int t;
    if (reset) begin
      model_reset();
      return;
    end
    wev = wr_frame_start || m_wpend;
    rev = rd_frame_start || m_rpend;
    wsw = wev && !(m_bact && m_bwrite);
    rsw = rev && !(m_bact && !m_bwrite);
    m_wpend = wev && !wsw;
    m_rpend = rev && !rsw;
    m_drop = 0; m_rep = 0;
    if (wsw) begin
      if (m_woff == TB_BANK) begin
        m_l = m_w; m_w = 3 - m_w - m_r; m_lv = 1;
      end else m_drop = 1;
      m_woff = 0;
    end
    if (rsw) begin
      if (m_lv) begin
        t = m_r; m_r = m_l; m_l = t; m_lv = 0;
      end else m_rep = 1;
      m_roff = 0;
    end
    if (!m_bact) begin
      we = wr_req && (m_woff < TB_BANK);
      re = rd_req && (m_roff < TB_BANK);
      if (we || re) begin
        m_bwrite = (we && re) ? !m_lastw : we;
        m_lastw = m_bwrite;
        m_bact = 1; m_acc = 0;
        m_write = m_bwrite; m_len = TB_LEN;
        m_addr = m_bwrite ? (longint'(TB_BASE) + m_w * longint'(TB_BANK) + m_woff)
                          : (longint'(TB_BASE) + m_r * longint'(TB_BANK) + m_roff);
      end
    end else if (!m_acc) begin
      if (cmd_ready) m_acc = 1;
    end else if (burst_done) begin
      if (m_bwrite) m_woff = (m_woff + TB_STRIDE > TB_BANK) ? TB_BANK : m_woff + TB_STRIDE;
      else          m_roff = (m_roff + TB_STRIDE > TB_BANK) ? TB_BANK : m_roff + TB_STRIDE;
      m_bact = 0;
    end
  endfunction

  // Newly issued commands, captured for literal checks.
  bit     cap_w[$];
  longint cap_a[$];
  bit     prev_valid = 0;

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("cmd_valid",    cif.cmd_valid, m_bact && !m_acc);
    chk("cmd_write",    cif.cmd_write, m_write);
    chk("cmd_addr",     cif.cmd_addr,  m_addr);
    chk("cmd_len",      cif.cmd_len,   m_len);
    chk("wr_bank",      wr_bank,       m_w);
    chk("rd_bank",      rd_bank,       m_r);
    chk("frame_drop",   frame_drop,    m_drop);
    chk("frame_repeat", frame_repeat,  m_rep);
    chk("busy",         busy,          m_bact);
    if (cif.cmd_valid && !prev_valid) begin
      cap_w.push_back(cif.cmd_write);
      cap_a.push_back(longint'(cif.cmd_addr));
    end
    prev_valid = cif.cmd_valid;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    reset = 1; wr_frame_start = 0; rd_frame_start = 0;
    wr_req = 0; rd_req = 0; cmd_ready = 0; burst_done = 0;
    run(2);
    reset = 0;
  endtask

  task automatic chk_cap(string nm, int idx, bit w, longint a);
    if (cap_w.size() <= idx) begin
      chk({nm, "_present"}, cap_w.size(), idx + 1);
    end else begin
      chk({nm, "_write"}, cap_w[idx], w);
      chk({nm, "_addr"},  cap_a[idx], a);
    end
  endtask

  initial begin
    model_reset();
    do_reset();
    chk("rst_wr_bank", wr_bank, 0);
    chk("rst_rd_bank", rd_bank, 1);
    chk("rst_valid",   cif.cmd_valid, 0);
    chk("rst_busy",    busy, 0);

    // Tie arbitration: read first, then alternate.
    cap_w.delete(); cap_a.delete();
    wr_req = 1; rd_req = 1; cmd_ready = 1; burst_done = 1;
    run(12);
    chk_cap("tie0", 0, 0, TB_BASE + TB_BANK);
    chk_cap("tie1", 1, 1, TB_BASE);
    chk_cap("tie2", 2, 0, TB_BASE + TB_BANK + TB_STRIDE);
    chk_cap("tie3", 3, 1, TB_BASE + TB_STRIDE);

    // Finish the write frame on bank 0, swap, then the reader takes it.
    rd_req = 0;
    run(21);
    wr_req = 0;
    run(1);
    wr_frame_start = 1; cycle(); wr_frame_start = 0;
    chk("full_wr_bank", wr_bank, 2);
    rd_frame_start = 1; cycle(); rd_frame_start = 0;
    chk("full_rd_bank", rd_bank, 0);
    chk("full_no_repeat", frame_repeat, 0);
    cap_w.delete(); cap_a.delete();
    rd_req = 1; cycle(); rd_req = 0;
    chk_cap("full_rd0", 0, 0, TB_BASE);
    run(2);

    // Incomplete write frame on bank 2 is dropped.
    wr_req = 1; run(9); wr_req = 0; run(1);
    wr_frame_start = 1; cycle(); wr_frame_start = 0;
    chk("drop_pulse", frame_drop, 1);
    chk("drop_wr_bank", wr_bank, 2);
    cycle();
    chk("drop_pulse_end", frame_drop, 0);
    cap_w.delete(); cap_a.delete();
    wr_req = 1; cycle(); wr_req = 0;
    chk_cap("drop_wr0", 0, 1, TB_BASE + 2 * TB_BANK);
    run(2);

    // Read frame with nothing new.
    rd_frame_start = 1; cycle(); rd_frame_start = 0;
    chk("repeat_pulse", frame_repeat, 1);
    chk("repeat_rd_bank", rd_bank, 0);

    // Complete bank 2, then a read frame start deferred behind a read burst.
    wr_req = 1; run(24); wr_req = 0; run(1);
    wr_frame_start = 1; cycle(); wr_frame_start = 0;
    chk("defer_wr_bank", wr_bank, 1);
    rd_req = 1; burst_done = 0;
    run(2);
    rd_frame_start = 1; cycle(); rd_frame_start = 0;
    run(2);
    chk("defer_held", rd_bank, 0);
    burst_done = 1; cycle();
    cap_w.delete(); cap_a.delete();
    cycle();
    chk("defer_applied", rd_bank, 2);
    chk_cap("defer_rd0", 0, 0, TB_BASE + 2 * TB_BANK);
    rd_req = 0; run(3);

    // Simultaneous swaps after a complete frame on bank 0.
    do_reset();
    wr_req = 1; cmd_ready = 1; burst_done = 1;
    run(24); wr_req = 0; run(1);
    wr_frame_start = 1; rd_frame_start = 1; cycle();
    wr_frame_start = 0; rd_frame_start = 0;
    chk("sim_wr_bank", wr_bank, 2);
    chk("sim_rd_bank", rd_bank, 0);
    chk("sim_no_repeat", frame_repeat, 0);

    // Randomized traffic, including stray handshakes and mid-burst resets.
    for (int i = 0; i < 20000; i++) begin
      reset          = ($urandom_range(0, 1999) == 0);
      wr_req         = ($urandom_range(0, 3) != 0);
      rd_req         = ($urandom_range(0, 3) != 0);
      cmd_ready      = $urandom_range(0, 1);
      burst_done     = ($urandom_range(0, 2) == 0);
      wr_frame_start = ($urandom_range(0, 59) == 0);
      rd_frame_start = ($urandom_range(0, 59) == 0);
      cycle();
    end
    reset = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
